// File: rtl/alu_serial_seq.sv
// Bit-serial ALU: one add/logic slice walks a WIDTH-bit operand pair LSB first,
// accumulating carry/equality/sign state, then publishes a registered result and flags.
module alu_serial_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [2:0]       bonus_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int unsigned IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_CMP = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       ctrl;
    logic [2:0]       bonus;
    logic [WIDTH-1:0] sreg;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             eq;
    logic             ovf;
    logic             less;

    logic             a;
    logic             b;
    logic             sum;
    logic             cnext;
    logic             bitv;

    always_comb begin
        a     = op_a[idx] ^ ctrl[3];
        b     = op_b[idx] ^ ctrl[2];
        sum   = a ^ b ^ carry;
        cnext = (a & b) | (a & carry) | (b & carry);
        case (ctrl)
            OP_AND, OP_NOR: bitv = a & b;
            OP_OR:          bitv = a | b;
            default:        bitv = sum;
        endcase
    end

    logic             cmp_flag;
    logic [WIDTH-1:0] fin_res;
    logic             fin_cout;
    logic             fin_ovf;

    always_comb begin
        case (bonus)
            3'd0:    cmp_flag = less;
            3'd1:    cmp_flag = ~less & ~eq;
            3'd2:    cmp_flag = less | eq;
            3'd3:    cmp_flag = ~less;
            3'd4:    cmp_flag = eq;
            3'd5:    cmp_flag = ~eq;
            default: cmp_flag = 1'b0;
        endcase

        fin_res  = '0;
        fin_cout = 1'b0;
        fin_ovf  = 1'b0;
        case (ctrl)
            OP_AND, OP_OR, OP_NOR: fin_res = sreg;
            OP_ADD, OP_SUB: begin
                fin_res  = sreg;
                fin_cout = carry;
                fin_ovf  = ovf;
            end
            OP_CMP: begin
                fin_res[0] = cmp_flag;
                fin_cout   = carry;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            result_o   <= '0;
            zero_o     <= 1'b0;
            cout_o     <= 1'b0;
            overflow_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            idx        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            ctrl       <= '0;
            bonus      <= '0;
            sreg       <= '0;
            carry      <= 1'b0;
            eq         <= 1'b0;
            ovf        <= 1'b0;
            less       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        op_a   <= src1_i;
                        op_b   <= src2_i;
                        ctrl   <= ctrl_i;
                        bonus  <= bonus_i;
                        carry  <= ctrl_i[2];
                        eq     <= 1'b1;
                        idx    <= '0;
                        busy_o <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sreg[idx] <= bitv;
                    carry     <= cnext;
                    eq        <= eq & ~(op_a[idx] ^ op_b[idx]);
                    if (idx == LAST) begin
                        // carry still holds the MSB carry-in here
                        ovf   <= carry ^ cnext;
                        less  <= sum ^ (carry ^ cnext);
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    result_o   <= fin_res;
                    zero_o     <= (fin_res == '0);
                    cout_o     <= fin_cout;
                    overflow_o <= fin_ovf;
                    done_o     <= 1'b1;
                    busy_o     <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed self-checking bench for alu_serial_seq (WIDTH=32) with hand-computed expectations.
module tb_alu_serial_seq;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   ctrl;
    logic [2:0]   bonus;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         cout;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .ctrl_i     (ctrl),
        .bonus_i    (bonus),
        .src1_i     (src1),
        .src2_i     (src2),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (result),
        .zero_o     (zero),
        .cout_o     (cout),
        .overflow_o (overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] r, input logic z,
                              input logic c, input logic o);
        check({tag, ".result"}, 64'(result), 64'(r));
        check({tag, ".zero"}, 64'(zero), 64'(z));
        check({tag, ".cout"}, 64'(cout), 64'(c));
        check({tag, ".ovf"}, 64'(overflow), 64'(o));
    endtask

    // mode 0: single-cycle start; 1: start held for whole run; 2: mid-run start pulse + input changes
    task automatic run_op(input string tag, input logic [3:0] c, input logic [2:0] bn,
                          input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
        int n;
        int busy_n;
        @(negedge clk);
        ctrl  = c;
        bonus = bn;
        src1  = a;
        src2  = b;
        start = 1'b1;
        @(negedge clk);
        if (mode != 1) start = 1'b0;
        n = 0;
        busy_n = 0;
        while (!done && n < 200) begin
            if (busy) busy_n++;
            if (mode == 2 && n == 5) begin
                start = 1'b1;
                src1  = ~a;
                ctrl  = 4'b0000;
            end
            if (mode == 2 && n == 6) start = 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, ".latency"}, 64'(n), 64'(W + 1));
        check({tag, ".busy_cycles"}, 64'(busy_n), 64'(W + 1));
    endtask

    task automatic check_quiet(input string tag);
        int busy_seen;
        busy_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || done) busy_seen++;
        end
        check({tag, ".no_relaunch"}, 64'(busy_seen), 64'd0);
    endtask

    logic [2:0] cmp_sel [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
    logic       cmp_exp [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        ctrl  = '0;
        bonus = '0;
        src1  = '0;
        src2  = '0;
        repeat (2) @(negedge clk);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        expect_out("reset", '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        run_op("add_ovf", 4'b0010, 3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        expect_out("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("add_ovf.done_pulse", 64'(done), 64'd0);
        check("add_ovf.hold", 64'(result), 64'h8000_0000);

        run_op("sub_eq", 4'b0110, 3'd0, 32'd5, 32'd5, 0);
        expect_out("sub_eq", 32'd0, 1'b1, 1'b1, 1'b0);

        run_op("sub_ovf", 4'b0110, 3'd0, 32'h8000_0000, 32'd1, 0);
        expect_out("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);

        for (int k = 0; k < 7; k++) begin
            run_op($sformatf("cmp_m1_1_b%0d", cmp_sel[k]), 4'b0111, cmp_sel[k],
                   32'hFFFF_FFFF, 32'd1, 0);
            expect_out($sformatf("cmp_m1_1_b%0d", cmp_sel[k]), W'(cmp_exp[k]),
                       ~cmp_exp[k], 1'b1, 1'b0);
        end

        run_op("cmp_7_7_seq", 4'b0111, 3'd4, 32'd7, 32'd7, 0);
        expect_out("cmp_7_7_seq", 32'd1, 1'b0, 1'b1, 1'b0);
        run_op("cmp_7_7_sle", 4'b0111, 3'd2, 32'd7, 32'd7, 0);
        expect_out("cmp_7_7_sle", 32'd1, 1'b0, 1'b1, 1'b0);
        run_op("cmp_7_7_slt", 4'b0111, 3'd0, 32'd7, 32'd7, 0);
        expect_out("cmp_7_7_slt", 32'd0, 1'b1, 1'b1, 1'b0);

        run_op("nor", 4'b1100, 3'd0, 32'd0, 32'd0, 0);
        expect_out("nor", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_op("and", 4'b0000, 3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        expect_out("and", 32'hF000_F000, 1'b0, 1'b0, 1'b0);
        run_op("or", 4'b0001, 3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        expect_out("or", 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);

        run_op("held_start", 4'b0010, 3'd0, 32'd10, 32'd20, 1);
        expect_out("held_start", 32'd30, 1'b0, 1'b0, 1'b0);
        check_quiet("held_start");

        run_op("midrun", 4'b0010, 3'd0, 32'd10, 32'd20, 2);
        expect_out("midrun", 32'd30, 1'b0, 1'b0, 1'b0);
        check_quiet("midrun");
        check("midrun.hold", 64'(result), 64'd30);

        @(negedge clk);
        ctrl  = 4'b0010;
        src1  = 32'd100;
        src2  = 32'd200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset.busy", 64'(busy), 64'd0);
        check("midreset.done", 64'(done), 64'd0);
        check("midreset.result", 64'(result), 64'd0);
        run_op("after_reset", 4'b0010, 3'd0, 32'd2, 32'd3, 0);
        expect_out("after_reset", 32'd5, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_serial_seq.md
# alu_serial_seq

Bit-serial ALU sequencer. It time-multiplexes a single one-bit add/logic slice across a WIDTH-bit operand pair, one bit per cycle, LSB first. It accumulates the carry, equality and sign information needed for the compare operations and presents a registered WIDTH-bit result with flags. It sits between the decode/control stage and the register write-back path in the area-reduced CPU variant, and replaces the parallel ripple ALU there.

## Interface
Parameters:
- WIDTH, 32, operand/result width (≥2)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  launch an operation; sampled only in IDLE
- ctrl_i  in  4  op select: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 COMPARE, 1100 NOR
- bonus_i  in  3  compare select (valid with COMPARE): 0 SLT, 1 SGT, 2 SLE, 3 SGE, 4 SEQ, 5 SNE, 6/7 constant 0
- src1_i  in  WIDTH  operand A, signed two's complement
- src2_i  in  WIDTH  operand B
- busy_o  out  1  high in RUN and DONE
- done_o  out  1  one-cycle pulse; result/flags valid from this cycle
- result_o  out  WIDTH  result
- zero_o  out  1  result_o == 0
- cout_o  out  1  carry out of the MSB
- overflow_o  out  1  signed overflow

## Operation
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - result_o = 0, zero_o = 0, cout_o = 0, overflow_o = 0.
  - busy_o = 0, done_o = 0.
  - Bit index = 0.
- States: IDLE → RUN → DONE → IDLE.
- IDLE, start_i=1:
  - Latch src1_i, src2_i, ctrl_i and bonus_i.
  - Decode A_inv = ctrl[3], B_inv = ctrl[2].
  - Set carry = B_inv. Set eq = 1 and index = 0.
  - Go to RUN.
- IDLE, start_i=0: remain in IDLE and hold all outputs.
- RUN, each cycle for bit i:
  - a = A[i]^A_inv and b = B[i]^B_inv.
  - The bit value is selected by op:
    - AND/NOR: a&b.
    - OR: a|b.
    - ADD/SUB/COMPARE: a^b^carry.
  - Shift the bit into the result register at position i.
  - carry ← ab | a·carry | b·carry.
  - eq ← eq & ~(A[i]^B[i]), using the raw operands.
- RUN, i = WIDTH−1:
  - ovf = carry_in(MSB) ^ carry_out(MSB).
  - less = sum(MSB) ^ ovf.
  - Go to DONE.
- DONE: update the outputs and pulse done_o, then return to IDLE next cycle.
  - AND/OR/NOR: result_o = shift register; cout_o = 0; overflow_o = 0.
  - ADD/SUB: result_o = sum; cout_o = carry out; overflow_o = ovf.
  - COMPARE: result_o = {0…, f}, where f is:
    - SLT: less
    - SGT: ~less & ~eq
    - SLE: less | eq
    - SGE: ~less
    - SEQ: eq
    - SNE: ~eq
    - 6/7: 0
  - COMPARE also sets cout_o = carry out and overflow_o = 0.
  - Undefined ctrl: result_o = 0, cout_o = 0, overflow_o = 0.
  - zero_o = (new result_o == 0) for every op.
- Output hold: outputs hold their last values until the next DONE; intermediate bits never appear on result_o.

## Timing
- Latency: start_i sampled at edge 0 → done_o high after edge WIDTH+1, i.e. WIDTH cycles in RUN plus 1 in DONE.
- Throughput: one op per WIDTH+2 cycles; IDLE costs at least one cycle between ops.
- start_i while busy_o=1 is ignored, with no queuing.
- Input capture: src/ctrl/bonus are captured only at the start edge; later changes have no effect.
- Reset mid-operation: rst_i in RUN or DONE forces IDLE and all reset values on the next edge.
  - A pending done_o is dropped.
  - rst_i has priority over start_i.

## Test plan
- ADD, WIDTH=32: 0x7FFFFFFF + 0x00000001 → result_o=0x80000000, overflow_o=1, cout_o=0, zero_o=0; done_o exactly 33 cycles after start.
- SUB: 5 − 5 → result_o=0, zero_o=1, cout_o=1, overflow_o=0. SUB 0x80000000 − 1 → 0x7FFFFFFF, overflow_o=1.
- COMPARE, src1=0xFFFFFFFF (−1), src2=1:
  - bonus 0 → 1; 1 → 0; 2 → 1; 3 → 0; 4 → 0; 5 → 1; 7 → 0.
  - Repeat with src1 = src2 = 7: bonus 4 → 1, 2 → 1, 0 → 0.
- Logic: NOR 0,0 → 0xFFFFFFFF; AND 0xF0F0F0F0,0xFF00FF00 → 0xF000F000; OR same → 0xFFF0FFF0; cout_o=0 and overflow_o=0 throughout.
- Handshake:
  - start_i held high for the whole run launches exactly one op.
  - A start pulse in mid-RUN is ignored.
  - Changing src1_i mid-RUN does not alter the result.
  - busy_o is high for exactly WIDTH+1 cycles.
- Reset: assert rst_i at RUN bit 10 → next cycle busy_o=0, done_o=0, result_o=0; a fresh ADD 2+3 then yields 5.
